// File: rtl/adder_arb_pkg.sv
// Shared types and constants for adder_share_arbiter.
// The rsp_t fields are sized for the largest supported configuration (N<=64, NREQ<=8).
package adder_arb_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int SUM_MAXW = 64;
  localparam int ID_MAXW  = 3;

  typedef struct packed {
    logic [ID_MAXW-1:0]  id;
    logic [SUM_MAXW-1:0] sum;
    logic                cout;
    logic                overflow;
  } rsp_t;

  // Signed clamp value for width w: most negative when neg=1, most positive otherwise.
  function automatic logic [SUM_MAXW-1:0] sat_limit(input int w, input logic neg);
    logic [SUM_MAXW-1:0] msb;
    msb = SUM_MAXW'(1) << (w - 1);
    return neg ? msb : msb - 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest rotated offset from ptr wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    j     = 0;
    // Walk offsets from farthest to nearest so the nearest valid request is the last write.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = en;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One signed adder shared by NREQ requesters, round-robin, one-entry output register.
// Optional ADDER_ARB_SATURATE_EN clamps rsp_sum on signed overflow.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_overflow
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] grant;
  logic            can_accept;
  logic            fire;
  logic [N-1:0]    a_sel, b_sel, res_sum;
  logic            cin_sel, ovf;
  logic [N:0]      full;
  logic            rsp_vld_q;
  rsp_t            rsp_q, rsp_d;

  assign can_accept = !rsp_vld_q || rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_accept && !rst),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready = grant;
  assign fire      = |grant;

  assign a_sel   = req_a[gidx*N +: N];
  assign b_sel   = req_b[gidx*N +: N];
  assign cin_sel = req_cin[gidx];
  assign full    = {1'b0, a_sel} + {1'b0, b_sel} + {{N{1'b0}}, cin_sel};
  assign ovf     = (a_sel[N-1] == b_sel[N-1]) && (full[N-1] != a_sel[N-1]);

`ifdef ADDER_ARB_SATURATE_EN
  logic [SUM_MAXW-1:0] lim;
  // Overflow only happens with equal operand signs, so A's sign picks the rail.
  assign lim     = sat_limit(N, a_sel[N-1]);
  assign res_sum = ovf ? lim[N-1:0] : full[N-1:0];
`else
  assign res_sum = full[N-1:0];
`endif

  always_comb begin
    rsp_d             = '0;
    rsp_d.id[IDW-1:0] = gidx;
    rsp_d.sum[N-1:0]  = res_sum;
    rsp_d.cout        = full[N];
    rsp_d.overflow    = ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
      ptr       <= '0;
    end else if (fire) begin
      rsp_vld_q <= 1'b1;
      rsp_q     <= rsp_d;
      ptr       <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (rsp_ready) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign rsp_valid    = rsp_vld_q;
  assign rsp_id       = rsp_q.id[IDW-1:0];
  assign rsp_sum      = rsp_q.sum[N-1:0];
  assign rsp_cout     = rsp_q.cout;
  assign rsp_overflow = rsp_q.overflow;

  // Upper struct bits are always zero for narrower configurations.
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^{rsp_q.id, rsp_q.sum};

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (N=32, NREQ=4): vectors, corner sequences, random vs model.
module tb_adder_share_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout, rsp_overflow;

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference adder from signed/unsigned integer arithmetic.
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output logic [31:0] s, output logic co, output logic ov);
    longint u, sg;
    u  = longint'(a) + longint'(b) + longint'(cin);
    sg = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    s  = u[31:0];
    co = u[32];
    ov = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
`ifdef ADDER_ARB_SATURATE_EN
    if (ov) s = (sg > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h7FFF_FFFF - $urandom_range(0, 15);
      2:       return 32'h8000_0000 + $urandom_range(0, 15);
      default: return 32'hFFFF_FFFF - $urandom_range(0, 3);
    endcase
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] sum;
    logic        co, ov;
  } vec_t;

  vec_t vt[6];

  // Random-phase model state
  logic        p_vld[NREQ];
  logic [31:0] p_a[NREQ], p_b[NREQ];
  logic        p_cin[NREQ];
  logic        m_vld;
  int          m_id, m_ptr;
  logic [31:0] m_sum;
  logic        m_co, m_ov;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;

    vt[0] = '{0, 32'd20, 32'd30, 1'b0, 32'd50, 1'b0, 1'b0};
    vt[1] = '{2, -32'sd100, -32'sd423, 1'b0, -32'sd523, 1'b1, 1'b0};
    vt[2] = '{3, 32'd40, -32'sd50, 1'b1, -32'sd9, 1'b0, 1'b0};
`ifdef ADDER_ARB_SATURATE_EN
    vt[3] = '{1, 32'd2147483640, 32'd10, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vt[4] = '{0, -32'sd2147483640, -32'sd10, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
    vt[3] = '{1, 32'd2147483640, 32'd10, 1'b0, 32'h8000_0002, 1'b0, 1'b1};
    vt[4] = '{0, -32'sd2147483640, -32'sd10, 1'b0, 32'h7FFF_FFFE, 1'b1, 1'b1};
`endif
    vt[5] = '{3, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0};

    // Reset: req_ready low even with every request valid
    req_valid = '1;
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_flags", 64'({rsp_cout, rsp_overflow}), 64'd0);
    req_valid = '0;
    rst = 1'b0;

    // Table vectors: one requester at a time, response one cycle after handshake
    foreach (vt[v]) begin
      req_valid = '0;
      req_valid[vt[v].idx] = 1'b1;
      req_a[vt[v].idx*N +: N] = vt[v].a;
      req_b[vt[v].idx*N +: N] = vt[v].b;
      req_cin[vt[v].idx] = vt[v].cin;
      #1;
      chk($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'(1 << vt[v].idx));
      tick();
      req_valid = '0;
      chk($sformatf("vec%0d_valid", v), 64'(rsp_valid), 64'd1);
      chk($sformatf("vec%0d_id", v), 64'(rsp_id), 64'(vt[v].idx));
      chk($sformatf("vec%0d_sum", v), 64'(rsp_sum), 64'(vt[v].sum));
      chk($sformatf("vec%0d_cout", v), 64'(rsp_cout), 64'(vt[v].co));
      chk($sformatf("vec%0d_ovf", v), 64'(rsp_overflow), 64'(vt[v].ov));
    end
    tick();
    chk("drain_valid", 64'(rsp_valid), 64'd0);

    // Fairness: all valid, ids rotate 0,1,2,3,0,1 with one result per cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'(i * 100);
      req_b[i*N +: N] = 32'd1;
    end
    req_cin = '0;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("fair%0d_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("fair%0d_id", k), 64'(rsp_id), 64'(k % NREQ));
      chk($sformatf("fair%0d_sum", k), 64'(rsp_sum), 64'((k % NREQ) * 100 + 1));
    end
    req_valid = '0;
    tick();

    // Backpressure: response held, no grants while stalled, no bubble on release
    do_reset();
    req_a[0*N +: N] = 32'd5;
    req_b[0*N +: N] = 32'd0;
    req_a[1*N +: N] = 32'd7;
    req_b[1*N +: N] = 32'd0;
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0010;
    chk("bp_first_id", 64'(rsp_id), 64'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp%0d_id", k), 64'(rsp_id), 64'd0);
      chk($sformatf("bp%0d_sum", k), 64'(rsp_sum), 64'd5);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("bp_release_valid", 64'(rsp_valid), 64'd1);
    chk("bp_release_id", 64'(rsp_id), 64'd1);
    chk("bp_release_sum", 64'(rsp_sum), 64'd7);

    // Mid-stall reset: pending response discarded, pointer back to 0
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    rst = 1'b1;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mrst_valid", 64'(rsp_valid), 64'd0);
    chk("mrst_sum", 64'(rsp_sum), 64'd0);
    rst = 1'b0;
    req_a[1*N +: N] = 32'd11;
    req_a[3*N +: N] = 32'd33;
    req_b[3*N +: N] = 32'd0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    chk("mrst_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("mrst_id", 64'(rsp_id), 64'd1);
    chk("mrst_rsp_sum", 64'(rsp_sum), 64'd11);
    tick();

    // Random traffic against the model
    do_reset();
    m_vld = 1'b0; m_ptr = 0; m_id = 0; m_sum = '0; m_co = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < NREQ; i++) p_vld[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int w;
      logic [NREQ-1:0] exp_rdy;
      for (int i = 0; i < NREQ; i++) begin
        if (!p_vld[i] && ($urandom_range(0, 2) == 0)) begin
          p_vld[i] = 1'b1;
          p_a[i] = rnd_op();
          p_b[i] = rnd_op();
          p_cin[i] = 1'($urandom_range(0, 1));
        end
        req_valid[i] = p_vld[i];
        req_a[i*N +: N] = p_a[i];
        req_b[i*N +: N] = p_b[i];
        req_cin[i] = p_cin[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      w = -1;
      if (!m_vld || rsp_ready) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (p_vld[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      #1;
      chk("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
      tick();
      if (w >= 0) begin
        m_vld = 1'b1;
        m_id  = w;
        ref_add(p_a[w], p_b[w], p_cin[w], m_sum, m_co, m_ov);
        m_ptr = (w + 1) % NREQ;
        p_vld[w] = 1'b0;
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
      chk("rnd_valid", 64'(rsp_valid), 64'(m_vld));
      if (m_vld) begin
        chk("rnd_id", 64'(rsp_id), 64'(m_id));
        chk("rnd_sum", 64'(rsp_sum), 64'(m_sum));
        chk("rnd_flags", 64'({rsp_cout, rsp_overflow}), 64'({m_co, m_ov}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
